mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer and arbiter that shares one single-port synchronous memory between the CPU's instruction-fetch port and its data-memory port. It sits between the multicycle control/datapath and the unified memory. It serializes requests, drives the memory strobes for a parameterized read latency, and returns a one-cycle acknowledge with captured read data. Data accesses have priority, and a starvation guard protects instruction fetch.

## Interface
- AW, 32, address width
- DW, 32, data width
- WAIT, 1, memory read latency in cycles after the strobe cycle (≥1)
- STARVE, 4, maximum consecutive data grants while fetch is pending (≥1)

- CLK  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  AW  fetch address; stable while if_req
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DW  fetched word; holds until next fetch completes
- dm_req  in  1  data request; held until dm_ack
- dm_we  in  1  1 = write, 0 = read; stable while dm_req
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_ack  out  1  one-cycle pulse; dm_rdata valid on reads
- dm_rdata  out  DW  read word; holds until next data read completes
- mem_en  out  1  memory strobe
- mem_we  out  1  memory write enable; only high with mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid WAIT cycles after strobe cycle
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states:
  - IDLE: arbitrate among pending requests.
  - ISSUE: exactly one cycle; mem_en=1; mem_we=latched we.
  - WAIT: WAIT cycles, counted by a down-counter.
  - DONE: exactly one cycle; ack for the granted port.
- State transitions:
  - IDLE→ISSUE when any request is pending.
  - ISSUE→WAIT.
  - WAIT→DONE when the counter expires.
  - DONE→IDLE, unconditionally. The granted requester still holds req during DONE, so no arbitration happens there.
- At grant, latch port id, address, we and wdata into internal registers. mem_addr and mem_wdata come from these registers. Input changes after the grant are ignored.
- Fetch is always a read. Writes follow the same timing as reads, and the ack carries no data.
- Grant rule in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant data, unless starve_cnt == STARVE, in which case grant fetch.
- starve_cnt update:
  - +1 on each data grant made while if_req is high, saturating at STARVE.
  - Cleared on each fetch grant.
  - Cleared on a data grant while if_req is low.
- In the last WAIT cycle, capture mem_rdata into the rdata register of the granted port (data reads only). The other port's rdata register is untouched.
- Reset values:
  - Outputs: if_ack=0, dm_ack=0, mem_en=0, mem_we=0, busy=0; mem_addr, mem_wdata, if_rdata and dm_rdata all 0.
  - Internal: state IDLE, starve_cnt 0, wait counter 0.
- Reset mid-operation:
  - Next state is IDLE and no ack is issued. The requester must keep req high, and the access re-executes from IDLE.
  - If reset is low during the ISSUE cycle, the memory may still commit that write. Re-issue is idempotent, so this is acceptable.

## Timing
- Latency, with req first seen in IDLE in cycle 0:
  - Cycle 1: ISSUE.
  - Cycles 2..WAIT+1: WAIT.
  - Cycle WAIT+2: DONE, ack high.
  - Cycle WAIT+3: IDLE.
- Back-to-back cost is WAIT+3 cycles per access, including the one IDLE bubble.
- mem_en and mem_we are decoded from registered state; no combinational path runs from req to mem_*.
- if_ack and dm_ack are never high in the same cycle.

## Structure
- The shared package holds:
  - State enum, 2 bits: IDLE=00, ISSUE=01, WAIT=10, DONE=11.
  - Grant id constants: GNT_IF=0, GNT_DM=1.
- Sub-module mem_arb_pick: combinational picker from (if_req, dm_req, starve_cnt==STARVE) to (valid, grant id). Counter and FSM stay in the top.

## Test plan
- Reset: hold reset=0 for 3 cycles with both reqs high → all outputs 0, busy=0; after release, the first ISSUE appears in cycle 1 after the release edge.
- Single fetch, WAIT=1, mem[0x10]=0x20020001: if_req in cycle 0 → mem_en=1 and mem_addr=0x10 in cycle 1; if_ack=1 in cycle 3 with if_rdata=0x20020001; busy low in cycle 4.
- Data write then fetch: dm_we=1, addr 0x8, wdata 0xDEADBEEF → mem_we=1 in cycle 1 only and dm_ack in cycle 3. A following fetch of 0x8 then returns 0xDEADBEEF.
- Simultaneous reqs, WAIT=1, starve_cnt=0: dm_ack in cycle 3, fetch ISSUE in cycle 5, if_ack in cycle 7. dm_rdata is unaffected by the fetch.
- Starvation, STARVE=2: dm_req and if_req held continuously → grant order DM, DM, IF, DM, DM, IF.
- Reset mid-WAIT, WAIT=3: reset=0 in cycle 3 → IDLE in cycle 4, no ack. The held req restarts: ISSUE in cycle 5 after reset returns high.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter:
// FSM state encoding, grant identifiers and a counter-width helper.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } arb_state_e;

    typedef logic gnt_id_t;

    localparam gnt_id_t GNT_IF = 1'b0;
    localparam gnt_id_t GNT_DM = 1'b1;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational request picker for the memory port arbiter.
// Ports:
//   if_req, dm_req - pending fetch / data requests
//   starved        - starvation counter has reached its limit
//   valid_c        - at least one request pending
//   gnt_c          - port to grant (GNT_IF / GNT_DM)
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic    if_req,
    input  logic    dm_req,
    input  logic    starved,
    output logic    valid_c,
    output gnt_id_t gnt_c
);

    // Data wins a tie unless fetch has waited through too many data grants.
    always_comb begin
        valid_c = if_req | dm_req;
        gnt_c   = GNT_IF;
        if (dm_req && !(if_req && starved)) begin
            gnt_c = GNT_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// data access. Serializes requests through IDLE/ISSUE/WAIT/DONE, drives the
// memory strobes, captures read data and returns a one-cycle acknowledge.
// Ports:
//   CLK, reset                  - clock, synchronous active-low reset
//   if_req/if_addr              - fetch request (read only)
//   if_ack/if_rdata             - fetch acknowledge and fetched word
//   dm_req/dm_we/dm_addr/dm_wdata - data request
//   dm_ack/dm_rdata             - data acknowledge and read word
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory side
//   busy                        - arbiter is not in IDLE
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned WAIT   = 1,
    parameter int unsigned STARVE = 4
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int unsigned SCW = cnt_width(STARVE);
    localparam int unsigned WCW = cnt_width(WAIT - 1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE);
    localparam logic [WCW-1:0] WAIT_LOAD  = WCW'(WAIT - 1);

    arb_state_e    state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
    gnt_id_t       gnt_q, gnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic          busy_q, busy_d;

    logic          pick_valid;
    gnt_id_t       pick_gnt;

    mem_arb_pick u_pick (
        .if_req  (if_req),
        .dm_req  (dm_req),
        .starved (starve_cnt_q == STARVE_MAX),
        .valid_c (pick_valid),
        .gnt_c   (pick_gnt)
    );

    // Next-state, latched request and output decode.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        gnt_d        = gnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ISSUE;
                    gnt_d   = pick_gnt;
                    if (pick_gnt == GNT_DM) begin
                        we_d    = dm_we;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                        // Only data grants that bypass a waiting fetch count.
                        if (if_req) begin
                            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ?
                                           STARVE_MAX : starve_cnt_q + SCW'(1);
                        end else begin
                            starve_cnt_d = '0;
                        end
                    end else begin
                        we_d         = 1'b0;
                        addr_d       = if_addr;
                        starve_cnt_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                state_d    = ST_WAIT;
                wait_cnt_d = WAIT_LOAD;
            end
            ST_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = ST_DONE;
                    // Memory data is valid in the last wait cycle only.
                    if (!we_q) begin
                        if (gnt_q == GNT_DM) begin
                            dm_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - WCW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered versions of the upcoming state.
        mem_en_d = (state_d == ST_ISSUE);
        mem_we_d = (state_d == ST_ISSUE) && we_d;
        if_ack_d = (state_d == ST_DONE) && (gnt_d == GNT_IF);
        dm_ack_d = (state_d == ST_DONE) && (gnt_d == GNT_DM);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            gnt_q        <= GNT_IF;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            gnt_q        <= gnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            if_ack_q     <= if_ack_d;
            dm_ack_q     <= dm_ack_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            busy_q       <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance a: WAIT=1, STARVE=2 with a
// registered memory model. Instance b: WAIT=3 for reset-during-wait.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [DW-1:0] exp_dm_rdata;

    // Instance a signals
    logic          a_reset, a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack;
    logic          a_mem_en, a_mem_we, a_busy;
    logic [AW-1:0] a_if_addr, a_dm_addr, a_mem_addr;
    logic [DW-1:0] a_if_rdata, a_dm_wdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;

    // Instance b signals
    logic          b_reset, b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack;
    logic          b_mem_en, b_mem_we, b_busy;
    logic [AW-1:0] b_if_addr, b_dm_addr, b_mem_addr;
    logic [DW-1:0] b_if_rdata, b_dm_wdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(1), .STARVE(2)) dut_a (
        .CLK(CLK), .reset(a_reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_ack(a_dm_ack), .dm_rdata(a_dm_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(3), .STARVE(4)) dut_b (
        .CLK(CLK), .reset(b_reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_ack(b_dm_ack), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory for a: read data valid only in the cycle after the strobe.
    logic [DW-1:0] mem_a [0:63];
    logic [DW-1:0] rd_a;
    always @(posedge CLK) begin
        if (a_mem_en && a_mem_we) mem_a[a_mem_addr[5:0]] <= a_mem_wdata;
        if (a_mem_en && !a_mem_we) rd_a <= mem_a[a_mem_addr[5:0]];
        else rd_a <= 32'hBAD0_BAD0;
    end
    assign a_mem_rdata = rd_a;

    // Memory for b: data is the inverted address.
    assign b_mem_rdata = ~b_mem_addr;

    task automatic wait_idle_a();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (a_busy === 1'b0) seen = 1'b1;
        end
        vec_cnt++;
        if (!seen) begin
            err_cnt++;
            $display("FAIL idle_timeout: busy=%b required 0", a_busy);
        end
    endtask

    task automatic test_reset();
        a_reset = 1'b0; b_reset = 1'b0;
        a_if_req = 1'b1; a_if_addr = 32'h5;
        a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h4; a_dm_wdata = 32'h0;
        b_if_req = 1'b0; b_if_addr = '0; b_dm_req = 1'b0; b_dm_we = 1'b0;
        b_dm_addr = '0; b_dm_wdata = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        vec_cnt++;
        if ({a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_busy} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_ctl: got %b required 00000",
                     {a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_busy});
        end
        vec_cnt++;
        if ({a_mem_addr, a_mem_wdata} !== 64'h0) begin
            err_cnt++;
            $display("FAIL reset_mem_bus: got %h required 0", {a_mem_addr, a_mem_wdata});
        end
        vec_cnt++;
        if ({a_if_rdata, a_dm_rdata} !== 64'h0) begin
            err_cnt++;
            $display("FAIL reset_rdata: got %h required 0", {a_if_rdata, a_dm_rdata});
        end
        @(posedge CLK); #1;
        a_reset = 1'b1; b_reset = 1'b1;
        @(negedge CLK);  // cycle 0
        vec_cnt++;
        if ({a_mem_en, a_busy} !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_rel_c0: en,busy got %b required 00", {a_mem_en, a_busy});
        end
        @(negedge CLK);  // cycle 1: data wins the tie
        vec_cnt++;
        if ({a_mem_en, a_mem_we, a_mem_addr} !== {2'b10, 32'h4}) begin
            err_cnt++;
            $display("FAIL reset_rel_issue: got %b %b %h required 1 0 00000004",
                     a_mem_en, a_mem_we, a_mem_addr);
        end
        a_if_req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);  // cycle 3
        vec_cnt++;
        if ({a_dm_ack, a_dm_rdata} !== {1'b1, 32'hA000_0004}) begin
            err_cnt++;
            $display("FAIL reset_rel_ack: got %b %h required 1 a0000004", a_dm_ack, a_dm_rdata);
        end
        exp_dm_rdata = 32'hA000_0004;
        a_dm_req = 1'b0;
        wait_idle_a();
    endtask

    task automatic test_single_fetch();
        @(posedge CLK); #1;
        a_if_addr = 32'h10; a_if_req = 1'b1;
        @(negedge CLK);  // cycle 0
        @(negedge CLK);  // cycle 1
        vec_cnt++;
        if ({a_mem_en, a_mem_we, a_busy, a_mem_addr} !== {3'b101, 32'h10}) begin
            err_cnt++;
            $display("FAIL fetch_issue: en,we,busy %b%b%b addr %h required 101 00000010",
                     a_mem_en, a_mem_we, a_busy, a_mem_addr);
        end
        @(negedge CLK);  // cycle 2
        vec_cnt++;
        if ({a_mem_en, a_if_ack} !== 2'b00) begin
            err_cnt++;
            $display("FAIL fetch_wait: en,ack got %b required 00", {a_mem_en, a_if_ack});
        end
        @(negedge CLK);  // cycle 3
        vec_cnt++;
        if ({a_if_ack, a_dm_ack, a_if_rdata} !== {2'b10, 32'h2002_0001}) begin
            err_cnt++;
            $display("FAIL fetch_ack: acks %b%b rdata %h required 10 20020001",
                     a_if_ack, a_dm_ack, a_if_rdata);
        end
        a_if_req = 1'b0;
        @(negedge CLK);  // cycle 4
        vec_cnt++;
        if ({a_busy, a_if_ack} !== 2'b00) begin
            err_cnt++;
            $display("FAIL fetch_idle: busy,ack got %b required 00", {a_busy, a_if_ack});
        end
    endtask

    task automatic test_write_then_fetch();
        @(posedge CLK); #1;
        a_dm_we = 1'b1; a_dm_addr = 32'h8; a_dm_wdata = 32'hDEAD_BEEF; a_dm_req = 1'b1;
        @(negedge CLK);  // cycle 0
        @(negedge CLK);  // cycle 1
        vec_cnt++;
        if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {2'b11, 32'h8, 32'hDEAD_BEEF}) begin
            err_cnt++;
            $display("FAIL write_issue: %b%b %h %h required 11 00000008 deadbeef",
                     a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
        end
        a_dm_addr = 32'h9; a_dm_wdata = 32'h0;  // post-grant changes are ignored
        @(negedge CLK);  // cycle 2
        vec_cnt++;
        if ({a_mem_en, a_mem_we} !== 2'b00) begin
            err_cnt++;
            $display("FAIL write_we_pulse: en,we got %b required 00", {a_mem_en, a_mem_we});
        end
        @(negedge CLK);  // cycle 3
        vec_cnt++;
        if ({a_dm_ack, a_if_ack, a_dm_rdata} !== {2'b10, exp_dm_rdata}) begin
            err_cnt++;
            $display("FAIL write_ack: acks %b%b rdata %h required 10 %h",
                     a_dm_ack, a_if_ack, a_dm_rdata, exp_dm_rdata);
        end
        a_dm_req = 1'b0; a_dm_we = 1'b0;
        wait_idle_a();
        vec_cnt++;
        if (mem_a[9] !== 32'hA000_0009) begin
            err_cnt++;
            $display("FAIL write_latched_addr: mem[9] got %h required a0000009", mem_a[9]);
        end
        @(posedge CLK); #1;
        a_if_addr = 32'h8; a_if_req = 1'b1;
        repeat (4) @(negedge CLK);  // cycles 0..3
        vec_cnt++;
        if ({a_if_ack, a_if_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            err_cnt++;
            $display("FAIL write_readback: ack %b rdata %h required 1 deadbeef",
                     a_if_ack, a_if_rdata);
        end
        a_if_req = 1'b0;
        wait_idle_a();
    endtask

    task automatic test_simultaneous();
        @(posedge CLK); #1;
        a_dm_we = 1'b0; a_dm_addr = 32'h3; a_dm_req = 1'b1;
        a_if_addr = 32'h5; a_if_req = 1'b1;
        @(negedge CLK);  // cycle 0
        @(negedge CLK);  // cycle 1
        vec_cnt++;
        if ({a_mem_en, a_mem_addr} !== {1'b1, 32'h3}) begin
            err_cnt++;
            $display("FAIL sim_dm_first: en %b addr %h required 1 00000003", a_mem_en, a_mem_addr);
        end
        @(negedge CLK);
        @(negedge CLK);  // cycle 3
        vec_cnt++;
        if ({a_dm_ack, a_if_ack, a_dm_rdata} !== {2'b10, 32'hA000_0003}) begin
            err_cnt++;
            $display("FAIL sim_dm_ack: acks %b%b rdata %h required 10 a0000003",
                     a_dm_ack, a_if_ack, a_dm_rdata);
        end
        a_dm_req = 1'b0;
        @(negedge CLK);  // cycle 4
        vec_cnt++;
        if (a_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL sim_bubble: busy got %b required 0", a_busy);
        end
        @(negedge CLK);  // cycle 5
        vec_cnt++;
        if ({a_mem_en, a_mem_addr} !== {1'b1, 32'h5}) begin
            err_cnt++;
            $display("FAIL sim_if_issue: en %b addr %h required 1 00000005", a_mem_en, a_mem_addr);
        end
        @(negedge CLK);
        @(negedge CLK);  // cycle 7
        vec_cnt++;
        if ({a_if_ack, a_dm_ack, a_if_rdata, a_dm_rdata} !==
            {2'b10, 32'hA000_0005, 32'hA000_0003}) begin
            err_cnt++;
            $display("FAIL sim_if_ack: acks %b%b if %h dm %h required 10 a0000005 a0000003",
                     a_if_ack, a_dm_ack, a_if_rdata, a_dm_rdata);
        end
        a_if_req = 1'b0;
        wait_idle_a();
    endtask

    task automatic test_starvation();
        logic [5:0] order = '0;
        int n_ack = 0;
        int last_cyc = 0;
        bit both_hi = 1'b0;
        bit bad_gap = 1'b0;
        @(posedge CLK); #1;
        a_dm_we = 1'b0; a_dm_addr = 32'h1; a_dm_req = 1'b1;
        a_if_addr = 32'h2; a_if_req = 1'b1;
        for (int c = 0; c < 60 && n_ack < 6; c++) begin
            @(negedge CLK);
            if (a_if_ack && a_dm_ack) both_hi = 1'b1;
            if (a_if_ack || a_dm_ack) begin
                order[n_ack] = a_dm_ack;
                if (n_ack > 0 && (c - last_cyc) != 4) bad_gap = 1'b1;
                last_cyc = c;
                n_ack++;
            end
        end
        a_dm_req = 1'b0; a_if_req = 1'b0;
        vec_cnt++;
        if (n_ack != 6) begin
            err_cnt++;
            $display("FAIL starve_count: acks got %0d required 6", n_ack);
        end
        vec_cnt++;
        if (order !== 6'b011011) begin
            err_cnt++;
            $display("FAIL starve_order: got %b required 011011 (bit0 first, 1=DM)", order);
        end
        vec_cnt++;
        if (bad_gap || both_hi) begin
            err_cnt++;
            $display("FAIL starve_timing: gap_err %b both_acks %b required 0 0", bad_gap, both_hi);
        end
        vec_cnt++;
        if (a_if_rdata !== 32'hA000_0002) begin
            err_cnt++;
            $display("FAIL starve_if_rdata: got %h required a0000002", a_if_rdata);
        end
        wait_idle_a();
    endtask

    task automatic test_reset_mid_wait();
        bit early_ack = 1'b0;
        @(posedge CLK); #1;
        b_dm_we = 1'b0; b_dm_addr = 32'h7; b_dm_req = 1'b1;
        @(negedge CLK);  // cycle 0
        early_ack |= b_dm_ack;
        @(negedge CLK);  // cycle 1
        early_ack |= b_dm_ack;
        vec_cnt++;
        if ({b_mem_en, b_mem_addr} !== {1'b1, 32'h7}) begin
            err_cnt++;
            $display("FAIL rmw_issue: en %b addr %h required 1 00000007", b_mem_en, b_mem_addr);
        end
        @(negedge CLK);  // cycle 2
        early_ack |= b_dm_ack;
        @(posedge CLK); #1;
        b_reset = 1'b0;  // low through cycle 3
        @(negedge CLK);  // cycle 3
        early_ack |= b_dm_ack;
        vec_cnt++;
        if (b_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL rmw_busy_c3: got %b required 1", b_busy);
        end
        @(posedge CLK); #1;
        b_reset = 1'b1;
        @(negedge CLK);  // cycle 4
        early_ack |= b_dm_ack;
        vec_cnt++;
        if ({b_busy, b_mem_en, b_mem_addr, b_dm_rdata} !== {2'b00, 32'h0, 32'h0}) begin
            err_cnt++;
            $display("FAIL rmw_idle_c4: busy %b en %b addr %h rdata %h required 0 0 0 0",
                     b_busy, b_mem_en, b_mem_addr, b_dm_rdata);
        end
        @(negedge CLK);  // cycle 5
        early_ack |= b_dm_ack;
        vec_cnt++;
        if ({b_mem_en, b_mem_addr} !== {1'b1, 32'h7}) begin
            err_cnt++;
            $display("FAIL rmw_reissue: en %b addr %h required 1 00000007", b_mem_en, b_mem_addr);
        end
        repeat (3) begin
            @(negedge CLK);  // cycles 6..8
            early_ack |= b_dm_ack;
        end
        vec_cnt++;
        if (early_ack !== 1'b0) begin
            err_cnt++;
            $display("FAIL rmw_no_early_ack: got %b required 0", early_ack);
        end
        @(negedge CLK);  // cycle 9
        vec_cnt++;
        if ({b_dm_ack, b_dm_rdata} !== {1'b1, 32'hFFFF_FFF8}) begin
            err_cnt++;
            $display("FAIL rmw_ack: ack %b rdata %h required 1 fffffff8", b_dm_ack, b_dm_rdata);
        end
        b_dm_req = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_a[i] = 32'hA000_0000 | 32'(i);
        mem_a[16] = 32'h2002_0001;
        exp_dm_rdata = '0;
        test_reset();
        test_single_fetch();
        test_write_then_fetch();
        test_simultaneous();
        test_starvation();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
